pipe_register: RTL and testbench

Fully registered two-entry valid-ready pipeline slice. It registers the forward path (o_valid, o_data) and the backward path (o_ready), so every output comes straight from a flop. It sits at any stream boundary that needs timing isolation in both directions, at full throughput and 1-cycle latency.

---
 rtl/pipe_register.sv | 162 ++++++++++++++++
 tb/tb_pipe_register.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_register.sv
// -----------------------------------------------------------------------------
// pipe_register
//
// Fully registered two-entry valid/ready pipeline slice. It isolates timing in
// both directions: o_valid, o_data and o_ready all come directly from flops.
// It sustains one beat per cycle with one cycle of latency. A second (skid)
// entry absorbs the beat that arrives in the same cycle the slice fills.
//
// Handshake: a beat moves across an interface on a rising edge where valid and
// ready are both 1. A sender that raises valid keeps valid and data stable
// until that transfer happens. Readiness never depends on valid.
//
// Parameters:
//   DWIDTH     data width in bits
//   CNT_WIDTH  performance counter width (only with PIPE_REG_PERF_EN)
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   i_data       upstream data
//   i_valid      upstream data valid
//   o_ready      ready to upstream (registered)
//   o_data       downstream data (registered)
//   o_valid      downstream data valid (registered)
//   i_ready      downstream ready
//   o_xfer_cnt   saturating count of accepted input beats   (PIPE_REG_PERF_EN)
//   o_stall_cnt  saturating count of downstream stall cycles (PIPE_REG_PERF_EN)
//
// Optional feature macro: PIPE_REG_PERF_EN. When it is defined, the two
// performance counters are added. When it is not defined, the counter ports
// and the counter logic do not exist.
//
// Debug visibility: the state register bits are the o_valid and o_ready
// outputs, so o_valid and o_ready together show the full FSM state.
// -----------------------------------------------------------------------------
module pipe_register #(
  parameter int DWIDTH = 8
`ifdef PIPE_REG_PERF_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready
`ifdef PIPE_REG_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] o_xfer_cnt,
  output logic [CNT_WIDTH-1:0] o_stall_cnt
`endif
);

  // State encoding is {valid, ready}. Each output is therefore one state bit.
  localparam logic [1:0] ST_EMPTY = 2'b01;
  localparam logic [1:0] ST_BUSY  = 2'b11;
  localparam logic [1:0] ST_FULL  = 2'b10;

  logic [1:0]        r_state;
  logic [DWIDTH-1:0] r_out;
  logic [DWIDTH-1:0] r_skid;

  logic [1:0] w_state_nxt;
  logic       w_in_xfer;
  logic       w_out_xfer;
  logic       w_load_out;
  logic       w_out_from_skid;
  logic       w_load_skid;

  assign o_valid = r_state[1];
  assign o_ready = r_state[0];
  assign o_data  = r_out;

  assign w_in_xfer  = i_valid && o_ready;
  assign w_out_xfer = o_valid && i_ready;

  always_comb begin
    w_state_nxt     = r_state;
    w_load_out      = 1'b0;
    w_out_from_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_load_out  = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_in_xfer && w_out_xfer) begin
          w_load_out = 1'b1;
        end else if (w_in_xfer) begin
          // The output entry is still stalled, so the new beat waits in skid.
          w_load_skid = 1'b1;
          w_state_nxt = ST_FULL;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // o_ready is 0 here, so w_in_xfer cannot occur and i_valid is ignored.
        if (w_out_xfer) begin
          w_load_out      = 1'b1;
          w_out_from_skid = 1'b1;
          w_state_nxt     = ST_BUSY;
        end
      end
      default: begin
        // 2'b00 is unreachable. Recover to a clean, empty slice.
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_out) begin
        r_out <= w_out_from_skid ? r_skid : i_data;
      end
      if (w_load_skid) begin
        r_skid <= i_data;
      end
    end
  end

`ifdef PIPE_REG_PERF_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_xfer_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic                 w_stall;

  assign w_stall     = o_valid && !i_ready;
  assign o_xfer_cnt  = r_xfer_cnt;
  assign o_stall_cnt = r_stall_cnt;

  // Both counters hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_in_xfer && (r_xfer_cnt != '1)) begin
        r_xfer_cnt <= r_xfer_cnt + CNT_ONE;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_register.sv
// -----------------------------------------------------------------------------
// tb_pipe_register
//
// Directed and random stimulus for pipe_register. A scoreboard queue holds
// every accepted beat. Each output transfer pops the oldest entry and
// compares it. Inputs change on the falling edge, and outputs are sampled
// there as well.
// -----------------------------------------------------------------------------
module tb_pipe_register;

  localparam int DW = 8;
`ifdef PIPE_REG_PERF_EN
  localparam int CW = 4;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
`ifdef PIPE_REG_PERF_EN
  logic [CW-1:0] o_xfer_cnt;
  logic [CW-1:0] o_stall_cnt;
`endif

  always #5 clk = ~clk;

`ifdef PIPE_REG_PERF_EN
  pipe_register #(.DWIDTH(DW), .CNT_WIDTH(CW)) dut (
`else
  pipe_register #(.DWIDTH(DW)) dut (
`endif
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready)
`ifdef PIPE_REG_PERF_EN
    ,
    .o_xfer_cnt (o_xfer_cnt),
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock. The handshakes are decided by the values present just
  // before the rising edge, and the outputs are checked at the next falling edge.
  task automatic cycle();
    logic          stall;
    logic [DW-1:0] held;
    logic [DW-1:0] e;
    stall = !rst && o_valid && !i_ready;
    held  = o_data;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (o_valid && i_ready) begin
        chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_data", 32'(o_data), 32'(e));
        end
      end
      if (i_valid && o_ready) begin
        exp_q.push_back(i_data);
        n_acc++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (stall) begin
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_data", 32'(o_data), 32'(held));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    rst     = 1'b1;
    i_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    i_valid = v;
    i_data  = d;
    i_ready = r;
    cycle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int start_acc;
    int budget;
    rst     = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b0;
    @(negedge clk);

    // Reset, then idle.
    do_reset(2);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_data", 32'(o_data), 32'h00);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 8'hFF, 1'b0);
      chk("idle_valid", 32'(o_valid), 32'd0);
      chk("idle_ready", 32'(o_ready), 32'd1);
      chk("idle_data", 32'(o_data), 32'h00);
    end

    // Streaming: each beat should appear one cycle after it is accepted.
    for (int k = 1; k <= 16; k++) begin
      chk("stream_ready", 32'(o_ready), 32'd1);
      drive(1'b1, DW'(k), 1'b1);
      chk("stream_valid", 32'(o_valid), 32'd1);
      chk("stream_data", 32'(o_data), 32'(k));
    end
    drive(1'b0, 8'h00, 1'b1);
    chk("stream_drained", 32'(o_valid), 32'd0);

    // Backpressure fill.
    drive(1'b1, 8'hA1, 1'b0);
    chk("bp_busy_valid", 32'(o_valid), 32'd1);
    chk("bp_busy_ready", 32'(o_ready), 32'd1);
    chk("bp_busy_data", 32'(o_data), 32'hA1);
    drive(1'b1, 8'hA2, 1'b0);
    chk("bp_full_ready", 32'(o_ready), 32'd0);
    chk("bp_full_data", 32'(o_data), 32'hA1);
    drive(1'b1, 8'hA3, 1'b0);
    chk("bp_ignore_ready", 32'(o_ready), 32'd0);
    chk("bp_ignore_q", 32'(exp_q.size()), 32'd2);
    drive(1'b0, 8'h00, 1'b1);
    chk("bp_drain1_data", 32'(o_data), 32'hA2);
    chk("bp_drain1_ready", 32'(o_ready), 32'd1);
    drive(1'b0, 8'h00, 1'b1);
    chk("bp_drain2_valid", 32'(o_valid), 32'd0);
    chk("bp_drain2_q", 32'(exp_q.size()), 32'd0);

    // Random valid and ready, with a cycle budget.
    start_acc = n_acc;
    budget    = 0;
    while ((n_acc - start_acc) < 1000 && budget < 20000) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      budget++;
    end
    chk("rand_accepted", 32'(n_acc - start_acc), 32'd1000);
    budget = 0;
    while (o_valid && budget < 10) begin
      drive(1'b0, 8'h00, 1'b1);
      budget++;
    end
    chk("rand_drain_valid", 32'(o_valid), 32'd0);
    chk("rand_drain_q", 32'(exp_q.size()), 32'd0);

    // Reset while FULL: both stored beats are discarded.
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    chk("mid_full_ready", 32'(o_ready), 32'd0);
    chk("mid_full_q", 32'(exp_q.size()), 32'd2);
    rst     = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_ready", 32'(o_ready), 32'd1);
    chk("mid_rst_data", 32'(o_data), 32'h00);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 8'h00, 1'b1);
      chk("mid_rst_quiet", 32'(o_valid), 32'd0);
    end

`ifdef PIPE_REG_PERF_EN
    // Saturating performance counters (CNT_WIDTH = 4).
    do_reset(1);
    chk("perf_rst_xfer", 32'(o_xfer_cnt), 32'd0);
    chk("perf_rst_stall", 32'(o_stall_cnt), 32'd0);
    for (int k = 0; k < 20; k++) drive(1'b1, DW'(k), 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    chk("perf_xfer_sat", 32'(o_xfer_cnt), 32'hF);
    chk("perf_no_stall", 32'(o_stall_cnt), 32'd0);
    do_reset(1);
    chk("perf_clr_xfer", 32'(o_xfer_cnt), 32'd0);
    drive(1'b1, 8'h55, 1'b0);
    for (int k = 0; k < 3; k++) drive(1'b0, 8'h00, 1'b0);
    chk("perf_stall3", 32'(o_stall_cnt), 32'd3);
    chk("perf_xfer1", 32'(o_xfer_cnt), 32'd1);
    do_reset(1);
    chk("perf_clr2_xfer", 32'(o_xfer_cnt), 32'd0);
    chk("perf_clr2_stall", 32'(o_stall_cnt), 32'd0);
`endif

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
